// File: rtl/lcd_bus_responder.sv
// Display-side model of an HD44780-style 8-bit parallel LCD bus.
// Holds a 2x16 DDRAM, answers busy/address and data reads, and exposes the buffer on a side port.
module lcd_bus_responder #(
  parameter int unsigned BUSY_CYCLES  = 4,
  parameter int unsigned CLEAR_CYCLES = 40
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rs,
  input  logic       rw,
  input  logic       en,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       data_oe,
  output logic       busy,
  output logic [6:0] ac,
  output logic       display_on,
  output logic       entry_inc,
  input  logic [4:0] view_addr,
  output logic [7:0] view_char,
  output logic       overrun
);

  localparam int unsigned DEPTH   = 32;
  localparam int unsigned CNT_MAX = (BUSY_CYCLES > CLEAR_CYCLES) ? BUSY_CYCLES : CLEAR_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {IDLE, EXEC, CLEAR} state_t;

  state_t           state;
  logic             en_q;
  logic             rs_l;
  logic             rw_l;
  logic [7:0]       data_l;
  logic [CNT_W-1:0] cnt;
  logic [4:0]       idx;
  logic [4:0]       clr_idx;
  logic             fill;
  logic [7:0]       ddram [DEPTH];

  logic       fall_c;
  logic       instr_rd_c;
  logic       start_c;
  logic       drop_c;
  logic       is_clr_c;
  logic       is_home_c;
  logic [4:0] idx_step_c;

  // Transaction qualification on the latched bus values at the enable fall.
  always_comb begin
    fall_c     = en_q & ~en;
    instr_rd_c = ~rs_l & rw_l;
    start_c    = fall_c & ~busy & ~instr_rd_c;
    drop_c     = fall_c & busy & ~instr_rd_c;
    is_clr_c   = ~rs_l & ~rw_l & (data_l == 8'h01);
    is_home_c  = ~rs_l & ~rw_l & (data_l[7:1] == 7'h01);
    idx_step_c = entry_inc ? (idx + 5'd1) : (idx - 5'd1);
  end

  assign ac        = {idx[4], 2'b00, idx[3:0]};
  assign view_char = ddram[view_addr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      en_q       <= 1'b0;
      rs_l       <= 1'b0;
      rw_l       <= 1'b0;
      data_l     <= 8'h00;
      cnt        <= '0;
      idx        <= '0;
      clr_idx    <= '0;
      fill       <= 1'b0;
      data_out   <= 8'h00;
      data_oe    <= 1'b0;
      busy       <= 1'b0;
      display_on <= 1'b0;
      entry_inc  <= 1'b1;
      overrun    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) ddram[i] <= 8'h20;
    end else begin
      en_q    <= en;
      overrun <= drop_c;
      if (en) begin
        rs_l   <= rs;
        rw_l   <= rw;
        data_l <= data_in;
      end

      // Read data is driven from live pins; data_out holds between reads.
      if (en && rw) begin
        data_oe  <= 1'b1;
        data_out <= rs ? ddram[idx] : {busy, ac};
      end else begin
        data_oe <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (start_c) begin
            busy <= 1'b1;
            if (is_clr_c || is_home_c) begin
              state   <= CLEAR;
              cnt     <= CNT_W'(CLEAR_CYCLES);
              fill    <= is_clr_c;
              clr_idx <= '0;
            end else begin
              state <= EXEC;
              cnt   <= CNT_W'(BUSY_CYCLES);
            end
            if (rs_l) begin
              if (!rw_l) ddram[idx] <= data_l;
              idx <= idx_step_c;
            end else begin
              casez (data_l)
                8'b1???????: idx <= {data_l[6], data_l[3:0]};
                8'b01??????: ;
                8'b001?????: ;
                8'b0001????: if (!data_l[3]) idx <= data_l[2] ? (idx + 5'd1) : (idx - 5'd1);
                8'b00001???: display_on <= data_l[2];
                8'b000001??: entry_inc <= data_l[1];
                8'b0000001?: idx <= '0;
                8'b00000001: begin
                  idx       <= '0;
                  entry_inc <= 1'b1;
                end
                default: ;
              endcase
            end
          end
        end
        EXEC, CLEAR: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
          // Clear fills one entry per cycle while the busy window runs.
          if (state == CLEAR && fill) begin
            ddram[clr_idx] <= 8'h20;
            clr_idx        <= clr_idx + 5'd1;
            if (clr_idx == 5'd31) fill <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_bus_responder.sv
// Directed bench for lcd_bus_responder: bus writes/reads, busy timing, clear, wrap and reset.
module tb_lcd_bus_responder;

  localparam int BUSY  = 4;
  localparam int CLEAR = 40;

  logic       clk = 1'b0;
  logic       reset;
  logic       rs, rw, en;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       data_oe, busy, display_on, entry_inc, overrun;
  logic [6:0] ac;
  logic [4:0] view_addr;
  logic [7:0] view_char;

  int n_cmp = 0;
  int n_bad = 0;

  lcd_bus_responder #(.BUSY_CYCLES(BUSY), .CLEAR_CYCLES(CLEAR)) dut (
    .clk(clk), .reset(reset), .rs(rs), .rw(rw), .en(en), .data_in(data_in),
    .data_out(data_out), .data_oe(data_oe), .busy(busy), .ac(ac),
    .display_on(display_on), .entry_inc(entry_inc), .view_addr(view_addr),
    .view_char(view_char), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench 1 time unit after the edge that executes the fall.
  task automatic bus_write(input logic r, input logic [7:0] d);
    rs = r; rw = 1'b0; data_in = d; en = 1'b1;
    step();
    en = 1'b0;
    step();
  endtask

  task automatic wait_busy(input string tag, input int exp);
    int n = 0;
    while (busy === 1'b1 && n < 500) begin
      n++;
      step();
    end
    check(tag, n, exp);
  endtask

  task automatic bus_read(input logic r, output logic [7:0] d, output logic oe);
    rs = r; rw = 1'b1; en = 1'b1;
    step();
    d  = data_out;
    oe = data_oe;
    en = 1'b0; rw = 1'b0;
    step();
  endtask

  task automatic view(input string tag, input logic [4:0] a, input logic [7:0] exp);
    view_addr = a;
    #1;
    check(tag, view_char, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] rd;
    logic       oe;
    reset = 1'b0; en = 1'b0; rs = 1'b0; rw = 1'b0; data_in = 8'h00; view_addr = 5'd0;
    #23;
    check("rst_data_out", data_out, 8'h00);
    check("rst_data_oe", data_oe, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_ac", ac, 7'h00);
    check("rst_display_on", display_on, 1'b0);
    check("rst_entry_inc", entry_inc, 1'b1);
    check("rst_overrun", overrun, 1'b0);
    view("rst_ddram0", 5'd0, 8'h20);
    step();
    reset = 1'b1;
    step();

    // Function set then three characters; the second holds en across cycles.
    bus_write(1'b0, 8'h38); wait_busy("busy_fs", BUSY);
    bus_write(1'b1, 8'h48); wait_busy("busy_d0", BUSY);
    rs = 1'b1; rw = 1'b0; en = 1'b1; data_in = 8'h11;
    step();
    data_in = 8'h52;
    step();
    en = 1'b0;
    step();
    wait_busy("busy_d1_hold", BUSY);
    bus_write(1'b1, 8'h20); wait_busy("busy_d2", BUSY);
    view("ddram0", 5'd0, 8'h48);
    view("ddram1", 5'd1, 8'h52);
    view("ddram2", 5'd2, 8'h20);
    check("ac_after_3", ac, 7'h03);

    // Address 0x4F is line 1 col 15; next write wraps to index 0.
    bus_write(1'b0, 8'hCF); wait_busy("busy_addr", BUSY);
    bus_write(1'b1, 8'h41); wait_busy("busy_w31", BUSY);
    bus_write(1'b1, 8'h42); wait_busy("busy_w0", BUSY);
    view("wrap_ddram31", 5'd31, 8'h41);
    view("wrap_ddram0", 5'd0, 8'h42);
    check("wrap_ac", ac, 7'h01);

    bus_write(1'b0, 8'h0C); wait_busy("busy_disp", BUSY);
    check("display_on", display_on, 1'b1);

    // Fill, then clear with a write dropped mid-clear.
    bus_write(1'b0, 8'h80); wait_busy("busy_home_addr", BUSY);
    for (int i = 0; i < 32; i++) begin
      bus_write(1'b1, 8'(8'h60 + i));
      wait_busy("busy_fill", BUSY);
    end
    view("fill_ddram5", 5'd5, 8'h65);
    view("fill_ddram31", 5'd31, 8'h7F);
    check("fill_ac_wrapped", ac, 7'h00);
    bus_write(1'b0, 8'h01);
    check("clr_busy_start", busy, 1'b1);
    repeat (8) step();
    rs = 1'b1; rw = 1'b0; data_in = 8'h55; en = 1'b1;
    step();
    en = 1'b0;
    check("clr_overrun_pre", overrun, 1'b0);
    step();
    check("clr_overrun_pulse", overrun, 1'b1);
    step();
    check("clr_overrun_end", overrun, 1'b0);
    wait_busy("clr_busy_remain", CLEAR - 11);
    for (int i = 0; i < 32; i++) view($sformatf("clr_ddram%0d", i), 5'(i), 8'h20);
    check("clr_ac", ac, 7'h00);
    check("clr_entry_inc", entry_inc, 1'b1);

    // Decrement mode across the line boundary.
    bus_write(1'b0, 8'h04); wait_busy("busy_entry_dec", BUSY);
    check("entry_dec", entry_inc, 1'b0);
    bus_write(1'b0, 8'hC0); wait_busy("busy_addr40", BUSY);
    bus_write(1'b1, 8'h5A); wait_busy("busy_w16", BUSY);
    view("dec_ddram16", 5'd16, 8'h5A);
    check("dec_ac", ac, 7'h0F);

    // Reads: busy/address while busy and idle, then a data read.
    bus_write(1'b0, 8'h06); wait_busy("busy_entry_inc", BUSY);
    bus_write(1'b0, 8'h85); wait_busy("busy_addr5", BUSY);
    bus_write(1'b1, 8'h77); wait_busy("busy_w5", BUSY);
    bus_write(1'b0, 8'h84); wait_busy("busy_addr4", BUSY);
    bus_write(1'b1, 8'h58);
    bus_read(1'b0, rd, oe);
    check("ird_busy_oe", oe, 1'b1);
    check("ird_busy_data", rd, 8'h85);
    check("ird_busy_no_overrun", overrun, 1'b0);
    check("ird_oe_released", data_oe, 1'b0);
    wait_busy("ird_busy_remain", BUSY - 2);
    bus_read(1'b0, rd, oe);
    check("ird_idle_data", rd, 8'h05);
    check("ird_idle_not_busy", busy, 1'b0);
    bus_read(1'b1, rd, oe);
    check("drd_oe", oe, 1'b1);
    check("drd_data", rd, 8'h77);
    wait_busy("busy_drd", BUSY);
    check("drd_ac", ac, 7'h06);
    check("drd_data_held", data_out, 8'h77);

    // Reset asserted in the middle of a clear.
    bus_write(1'b0, 8'hC4); wait_busy("busy_addr44", BUSY);
    bus_write(1'b1, 8'h33); wait_busy("busy_w20", BUSY);
    view("pre_ddram20", 5'd20, 8'h33);
    bus_write(1'b0, 8'h01);
    repeat (11) step();
    view("midclr_ddram20", 5'd20, 8'h33);
    check("midclr_busy", busy, 1'b1);
    reset = 1'b0;
    #1;
    check("arst_busy", busy, 1'b0);
    check("arst_ac", ac, 7'h00);
    check("arst_display_on", display_on, 1'b0);
    check("arst_entry_inc", entry_inc, 1'b1);
    check("arst_data_out", data_out, 8'h00);
    check("arst_data_oe", data_oe, 1'b0);
    check("arst_overrun", overrun, 1'b0);
    for (int i = 0; i < 32; i++) view($sformatf("arst_ddram%0d", i), 5'(i), 8'h20);
    step();
    reset = 1'b1;
    step();
    bus_write(1'b1, 8'h4B); wait_busy("post_rst_busy", BUSY);
    view("post_rst_ddram0", 5'd0, 8'h4B);
    check("post_rst_ac", ac, 7'h01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
